// File: rtl/fp_sqrt_pkg.sv
// Shared types and helpers for the iterative floating-point square root
// and other FPU operations that reuse the operand classifier.
package fp_sqrt_pkg;

  // Controller states of the iterative square-root unit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Operand class encoding produced by fp_sqrt_classify.
  localparam int CLS_W = 3;
  localparam logic [CLS_W-1:0] CLS_ZERO = 3'd0;
  localparam logic [CLS_W-1:0] CLS_SUB  = 3'd1;
  localparam logic [CLS_W-1:0] CLS_NORM = 3'd2;
  localparam logic [CLS_W-1:0] CLS_INF  = 3'd3;
  localparam logic [CLS_W-1:0] CLS_QNAN = 3'd4;
  localparam logic [CLS_W-1:0] CLS_SNAN = 3'd5;

  // Exponent bias for an exponent field of exp_w bits.
  function automatic int unsigned exp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set only.
  // Returned zero-extended to 128 bits; callers truncate to their width.
  function automatic logic [127:0] canon_qnan(input int unsigned exp_w,
                                              input int unsigned man_w);
    logic [127:0] v;
    v = ((128'd1 << exp_w) - 128'd1) << man_w;
    v = v | (128'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_sqrt_classify.sv
// Combinational operand classifier: class, sign and mantissa leading-zero
// count, shared by several FPU operations.
module fp_sqrt_classify
  import fp_sqrt_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LZ_W  = $clog2(MAN_W + 1)
) (
  input  logic [EXP_W+MAN_W:0] a,
  output logic                 sign,
  output logic [CLS_W-1:0]     cls,
  output logic [LZ_W-1:0]      lzc
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign sign  = a[EXP_W+MAN_W];
  assign exp_f = a[EXP_W+MAN_W-1:MAN_W];
  assign man_f = a[MAN_W-1:0];

  // Decode the operand class from the exponent and mantissa fields.
  always_comb begin
    cls = CLS_NORM;
    if (&exp_f) begin
      if (man_f == '0) begin
        cls = CLS_INF;
      end else if (man_f[MAN_W-1]) begin
        cls = CLS_QNAN;
      end else begin
        cls = CLS_SNAN;
      end
    end else if (exp_f == '0) begin
      cls = (man_f == '0) ? CLS_ZERO : CLS_SUB;
    end
  end

  // Leading zeros of the mantissa field; the highest set bit wins.
  always_comb begin
    lzc = LZ_W'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (man_f[i]) begin
        lzc = LZ_W'(MAN_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_sqrt_iter.sv
// Iterative floating-point square root: one restoring root bit per cycle,
// round-to-nearest-even, valid/ready handshake on both sides.
module fp_sqrt_iter
  import fp_sqrt_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   nv,
  output logic                   nx
);

  localparam int W     = 1 + EXP_W + MAN_W;
  // Root width: hidden bit, MAN_W fraction bits and one guard bit.
  localparam int SIG_W = MAN_W + 2;
  // Radicand holds one bit pair per root bit.
  localparam int RAD_W = 2 * SIG_W;
  // Partial remainder never exceeds 2*root, plus two freshly shifted bits.
  localparam int REM_W = SIG_W + 3;
  localparam int CNT_W = $clog2(MAN_W + 3);
  localparam int LZ_W  = $clog2(MAN_W + 1);
  // Signed unbiased exponent must cover the deepest subnormal.
  localparam int E_W   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
  localparam int BIAS  = int'(exp_bias(EXP_W));
  localparam logic [W-1:0]     QNAN      = W'(canon_qnan(EXP_W, MAN_W));
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAN_W + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RAD_W-1:0]   rad_q, rad_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [SIG_W-1:0]   root_q, root_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [W-1:0]       res_q, res_d;
  logic               nv_q, nv_d;
  logic               nx_q, nx_d;

  // Operand classification
  logic               cls_sign;
  logic [CLS_W-1:0]   cls;
  logic [LZ_W-1:0]    lzc;

  fp_sqrt_classify #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W),
    .LZ_W (LZ_W)
  ) u_classify (
    .a   (a),
    .sign(cls_sign),
    .cls (cls),
    .lzc (lzc)
  );

  // Accept-time normalisation
  logic [EXP_W-1:0]        a_exp;
  logic [MAN_W-1:0]        a_man;
  logic [MAN_W-1:0]        sub_frac;
  logic [MAN_W:0]          sig;
  logic signed [E_W-1:0]   e_unb;
  logic signed [E_W-1:0]   e_adj;
  logic signed [E_W-1:0]   e_half;
  logic [SIG_W-1:0]        sig_adj;
  logic [EXP_W-1:0]        exp_start;

  assign a_exp = a[W-2:MAN_W];
  assign a_man = a[MAN_W-1:0];

  // Normalise the operand and make the exponent even so it halves exactly.
  always_comb begin
    // Subnormal: shift the leading one out into the hidden position.
    sub_frac = a_man << (lzc + LZ_W'(1));
    sig      = {1'b1, (cls == CLS_NORM) ? a_man : sub_frac};
    if (cls == CLS_NORM) begin
      e_unb = E_W'(a_exp) - E_W'(BIAS);
    end else begin
      e_unb = E_W'(0) - E_W'(BIAS) - E_W'(lzc);
    end
    if (e_unb[0]) begin
      sig_adj = {sig, 1'b0};
      e_adj   = e_unb - E_W'(1);
    end else begin
      sig_adj = {1'b0, sig};
      e_adj   = e_unb;
    end
    e_half    = e_adj >>> 1;
    exp_start = EXP_W'(e_half + E_W'(BIAS));
  end

  // One restoring root step
  logic [REM_W-1:0]   rem_shift;
  logic [REM_W-1:0]   trial;
  logic               take;

  // Bring down the next radicand bit pair and try root*4+1 against it.
  always_comb begin
    rem_shift = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
    trial     = {1'b0, root_q, 2'b01};
    take      = (rem_shift >= trial);
  end

  // Rounding
  logic               guard;
  logic               sticky;
  logic               rnd_up;
  logic [MAN_W:0]     frac_sum;

  // Round-to-nearest-even on the root fraction; a carry out means the
  // fraction wrapped to zero and the exponent steps up by one.
  always_comb begin
    guard    = root_q[0];
    sticky   = |rem_q;
    rnd_up   = guard & (sticky | root_q[1]);
    frac_sum = {1'b0, root_q[MAN_W:1]} + (MAN_W + 1)'(rnd_up);
  end

  // Next-state, datapath and result update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    exp_d   = exp_q;
    res_d   = res_q;
    nv_d    = nv_q;
    nx_d    = nx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DONE;
          nv_d    = 1'b0;
          nx_d    = 1'b0;
          case (cls)
            CLS_ZERO: res_d = {cls_sign, {(W-1){1'b0}}};
            CLS_INF: begin
              if (cls_sign) begin
                res_d = QNAN;
                nv_d  = 1'b1;
              end else begin
                res_d = a;
              end
            end
            CLS_QNAN: res_d = QNAN;
            CLS_SNAN: begin
              res_d = QNAN;
              nv_d  = 1'b1;
            end
            default: begin
              if (cls_sign) begin
                res_d = QNAN;
                nv_d  = 1'b1;
              end else begin
                state_d = CALC;
                cnt_d   = '0;
                rad_d   = {sig_adj, {SIG_W{1'b0}}};
                rem_d   = '0;
                root_d  = '0;
                exp_d   = exp_start;
              end
            end
          endcase
        end
      end
      CALC: begin
        rad_d  = {rad_q[RAD_W-3:0], 2'b00};
        rem_d  = take ? (rem_shift - trial) : rem_shift;
        root_d = {root_q[SIG_W-2:0], take};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        res_d   = {1'b0, exp_q + EXP_W'(frac_sum[MAN_W]), frac_sum[MAN_W-1:0]};
        nv_d    = 1'b0;
        nx_d    = guard | sticky;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      nv_q    <= 1'b0;
      nx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      nv_q    <= nv_d;
      nx_q    <= nx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign nv        = nv_q;
  assign nx        = nx_q;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Directed and randomized checks of fp_sqrt_iter against an integer-sqrt
// reference model of IEEE single-precision square root.
module tb_fp_sqrt_iter;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        nv;
  logic        nx;

  int checks;
  int errors;

  fp_sqrt_iter #(
    .EXP_W(8),
    .MAN_W(23)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .nv       (nv),
    .nx       (nx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: exact square root by integer binary search, then RNE.
  task automatic ref_sqrt(input logic [31:0] x, output logic [31:0] r,
                          output logic rnv, output logic rnx, output int lat);
    logic   s;
    int     ex;
    int     e;
    longint mn, m, big, lo, hi, mid, root, q;
    logic   g, st;
    s   = x[31];
    ex  = int'(x[30:23]);
    mn  = longint'(x[22:0]);
    rnv = 1'b0;
    rnx = 1'b0;
    lat = 1;
    r   = QNAN;
    if (ex == 255) begin
      if (mn == 0 && !s) r = x;
      else if (mn == 0) rnv = 1'b1;
      else rnv = !x[22];
    end else if (ex == 0 && mn == 0) begin
      r = x;
    end else if (s) begin
      rnv = 1'b1;
    end else begin
      lat = 27;
      if (ex == 0) begin
        m = mn;
        e = -126;
      end else begin
        m = mn + (longint'(1) << 23);
        e = ex - 127;
      end
      while (m < (longint'(1) << 23)) begin
        m = m * 2;
        e = e - 1;
      end
      if (e % 2 != 0) begin
        m = m * 2;
        e = e - 1;
      end
      big = m * (longint'(1) << 25);
      lo  = 0;
      hi  = longint'(1) << 26;
      while (lo < hi) begin
        mid = (lo + hi + 1) / 2;
        if (mid * mid <= big) lo = mid;
        else hi = mid - 1;
      end
      root = lo;
      q    = root / 2;
      g    = (root % 2) == 1;
      st   = (root * root) != big;
      if (g && (st || (q % 2 == 1))) q = q + 1;
      e = e / 2;
      if (q == (longint'(1) << 24)) begin
        q = q / 2;
        e = e + 1;
      end
      r   = {1'b0, 8'(e + 127), 23'(q)};
      rnx = g | st;
    end
  endtask

  // Issue one operand and check result, flags, latency and handshake.
  task automatic run_op(input string tag, input logic [31:0] x,
                        input logic [31:0] er, input logic env, input logic enx,
                        input int elat, input int hold);
    int          lat;
    int          waitc;
    logic [31:0] junk;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    a         = x;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    if (!out_valid) begin
      junk     = $urandom;
      a        = junk;
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_res"}, result, er);
    chk({tag, "_nv"}, 32'(nv), 32'(env));
    chk({tag, "_nx"}, 32'(nx), 32'(enx));
    $display("op %s a=%h result=%h nv=%0d nx=%0d lat=%0d", tag, x, result, nv, nx, lat);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        a        = $urandom;
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_busy"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_res"}, result, er);
      chk({tag, "_hold_flags"}, {30'd0, nv, nx}, {30'd0, env, enx});
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_release"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  task automatic run_ref(input string tag, input logic [31:0] x, input int hold);
    logic [31:0] r;
    logic        rnv, rnx;
    int          lat;
    ref_sqrt(x, r, rnv, rnx, lat);
    run_op(tag, x, r, rnv, rnx, lat, hold);
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] specials [6];
    int          seen;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    out_ready = 1'b1;
    specials  = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                  32'hFF80_0000, 32'h7FC1_2345, 32'hFF80_0F00};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'd0, nv, nx}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed operands with known answers
    run_op("sqrt4", 32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0, 27, 0);
    run_op("sqrt2", 32'h4000_0000, 32'h3FB5_04F3, 1'b0, 1'b1, 27, 0);
    run_op("neg1", 32'hBF80_0000, QNAN, 1'b1, 1'b0, 1, 0);
    run_op("snan", 32'h7F80_0001, QNAN, 1'b1, 1'b0, 1, 0);
    run_op("qnan", 32'h7FC1_2345, QNAN, 1'b0, 1'b0, 1, 0);
    run_op("negzero", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1, 0);
    run_op("poszero", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1, 0);
    run_op("posinf", 32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0, 1, 0);
    run_op("neginf", 32'hFF80_0000, QNAN, 1'b1, 1'b0, 1, 0);
    run_op("minsub", 32'h0000_0001, 32'h1A35_04F3, 1'b0, 1'b1, 27, 0);
    run_ref("maxnorm", 32'h7F7F_FFFF, 0);
    run_ref("maxsub", 32'h007F_FFFF, 0);

    // Back-pressure: result held for 5 cycles, new operands ignored
    run_op("hold9", 32'h4110_0000, 32'h4040_0000, 1'b0, 1'b0, 27, 5);

    // Reset in the middle of a computation
    while (!in_ready) @(negedge clk);
    a        = 32'h4080_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    $display("op midrst out_valid_cycles=%0d", seen);
    run_op("after_rst9", 32'h4110_0000, 32'h4040_0000, 1'b0, 1'b0, 27, 0);

    // Randomized operands against the reference model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        1: x = {1'b0, 8'd0, 23'($urandom)};
        2: x = $urandom;
        default: x = specials[$urandom_range(0, 5)];
      endcase
      run_ref($sformatf("rnd%0d", n), x, (n % 10 == 3) ? 2 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
